partial_sum_accumulator: RTL

// - Consumer end of the adder-tree output. Takes the stream of signed per-chunk partial sums.
// - Each output element of a long dot product is split into CHUNKS tree-width slices.
// - Sums CHUNKS consecutive partial sums into one element. Packs OUT_LEN elements into a flat vector.
// - Hands the finished vector downstream over a valid/ready handshake.
// - Sits between the pipelined vec_mul adder trees and the result writeback.

---
 rtl/partial_sum_accumulator.sv | 121 ++++++++++++
 1 files changed

// File: rtl/partial_sum_accumulator.sv
// partial_sum_accumulator: folds CHUNKS signed partial sums into one element
// and packs OUT_LEN elements into a result vector handed off by valid/ready.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    partial-sum handshake; in_sum is signed, element-major
//   out_valid/out_ready  result-vector handshake; out_vec_flat element k at [k*ACC_BW +: ACC_BW]
//   busy                 high while any element is partially or fully accumulated
module partial_sum_accumulator #(
    parameter int PARTIAL_SUM_BW = 20,
    parameter int ACC_BW         = 24,
    parameter int CHUNKS         = 4,
    parameter int OUT_LEN        = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [PARTIAL_SUM_BW-1:0] in_sum,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_BW*OUT_LEN-1:0]        out_vec_flat,
    output logic                             busy
);

    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int EW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
    localparam logic [EW-1:0] LAST_ELEM  = EW'(OUT_LEN - 1);

    typedef enum logic {
        S_COLLECT,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]            r_chunk;
    logic [EW-1:0]            r_elem;
    logic signed [ACC_BW-1:0] r_acc;
    logic [ACC_BW-1:0]        r_elems [OUT_LEN];

    logic                     w_fire;
    logic                     w_last_chunk;
    logic                     w_last_elem;
    logic signed [ACC_BW-1:0] w_ext;
    logic signed [ACC_BW-1:0] w_sum;

    // Derived from the state directly so the handshake does not loop
    // back through the FSM output logic.
    assign w_fire       = in_valid && (r_state == S_COLLECT);
    assign w_last_chunk = (r_chunk == LAST_CHUNK);
    assign w_last_elem  = (r_elem == LAST_ELEM);

    // Signed size cast sign-extends the partial sum.
    assign w_ext = ACC_BW'(in_sum);

    // First chunk of an element discards whatever the accumulator held.
    assign w_sum = (r_chunk == '0) ? w_ext : r_acc + w_ext;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_COLLECT: begin
                in_ready = 1'b1;
                if (w_fire && w_last_chunk && w_last_elem) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
            r_chunk <= '0;
            r_elem  <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_acc <= w_sum;
                if (w_last_chunk) begin
                    r_chunk <= '0;
                    r_elem  <= w_last_elem ? '0 : r_elem + EW'(1);
                end else begin
                    r_chunk <= r_chunk + CW'(1);
                end
            end
        end
    end

    // Elements not rewritten keep the previous vector's value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < OUT_LEN; k++) begin
                r_elems[k] <= '0;
            end
        end else if (w_fire && w_last_chunk) begin
            r_elems[r_elem] <= w_sum;
        end
    end

    for (genvar g = 0; g < OUT_LEN; g++) begin : g_flat
        assign out_vec_flat[g*ACC_BW +: ACC_BW] = r_elems[g];
    end

    assign busy = (r_chunk != '0) || (r_elem != '0) || out_valid;

endmodule
